// File: rtl/sdram_layer_master.sv
// Avalon-MM master that evaluates one binary-input fully-connected layer from SDRAM
// and writes the saturated node sums back.
// state | meaning
// IDLE  | waiting for start
// RD    | issuing input and weight reads, bounded by MAX_OUTST in flight
// DRAIN | all reads issued, waiting for the remaining returns
// WR    | writing N_NODE results to OUT_BASE+k
// DONE  | pass finished, waiting for start to drop
module sdram_layer_master #(
  parameter int          DATA_W    = 16,
  parameter int          ACC_W     = 32,
  parameter int          N_IN      = 784,
  parameter int          N_NODE    = 200,
  parameter int          ADDR_W    = 32,
  parameter int unsigned IN_BASE   = 0,
  parameter int unsigned OUT_BASE  = 158000,
  parameter int          MAX_OUTST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                relu_en,
  output logic                done,
  output logic                busy,
  output logic [2:0]          state_o,
  output logic [ADDR_W-1:0]   address,
  output logic                read_n,
  output logic                write_n,
  output logic                chipselect,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                readdatavalid
);

  localparam int TOTAL  = N_IN * (N_NODE + 1);
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int IDX_W  = $clog2(N_IN + 1);
  localparam int NODE_W = $clog2(N_NODE + 1);

  localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  N_IN_C   = CNT_W'(N_IN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [NODE_W-1:0] NODE_CNT = NODE_W'(N_NODE);
  localparam logic [7:0]        MAX_O    = 8'(MAX_OUTST);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_DRAIN = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      relu_q, relu_d;
  logic                      read_n_q, read_n_d;
  logic                      write_n_q, write_n_d;
  logic [ADDR_W-1:0]         address_q, address_d;
  logic [DATA_W-1:0]         writedata_q, writedata_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [CNT_W-1:0]          issued_q, issued_d;
  logic [CNT_W-1:0]          received_q, received_d;
  logic [7:0]                outst_q, outst_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NODE_W-1:0]         node_q, node_d;
  logic [NODE_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N_IN-1:0]           in_bits_q, in_bits_d;
  logic [DATA_W-1:0]         res_q [N_NODE];
  logic [DATA_W-1:0]         res_d [N_NODE];

  logic                      rx_v, rd_acc, wr_acc, in_sel;
  logic signed [ACC_W-1:0]   w_ext, acc_sum, acc_pos;
  logic [DATA_W-1:0]         sat_val, res_pick;
  logic [NODE_W-1:0]         pick_idx;

  always_comb begin
    state_d     = state_q;
    relu_d      = relu_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    issued_d    = issued_q;
    received_d  = received_q;
    idx_d       = idx_q;
    node_d      = node_q;
    wr_cnt_d    = wr_cnt_q;
    acc_d       = acc_q;
    in_bits_d   = in_bits_q;
    res_d       = res_q;

    rx_v   = readdatavalid && (state_q == S_RD || state_q == S_DRAIN);
    rd_acc = (state_q == S_RD) && !read_n_q && !waitrequest;
    wr_acc = (state_q == S_WR) && !write_n_q && !waitrequest;

    in_sel = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (idx_q == IDX_W'(k)) in_sel = in_bits_q[k];
    end
    w_ext   = {{(ACC_W-DATA_W){readdata[DATA_W-1]}}, readdata};
    acc_sum = acc_q + (in_sel ? w_ext : '0);
    acc_pos = (relu_q && acc_sum[ACC_W-1]) ? '0 : acc_sum;
    if (acc_pos > SAT_HI)      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_pos < SAT_LO) sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    else                       sat_val = acc_pos[DATA_W-1:0];

    pick_idx = (state_q == S_WR) ? wr_cnt_q + NODE_W'(1) : '0;
    res_pick = '0;
    for (int k = 0; k < N_NODE; k++) begin
      if (pick_idx == NODE_W'(k)) res_pick = res_q[k];
    end

    outst_d = outst_q + {7'd0, rd_acc} - {7'd0, rx_v};

    // Returns are consumed independently of where the issue side is.
    if (rx_v) begin
      received_d = received_q + CNT_W'(1);
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (received_q < N_IN_C) begin
        for (int k = 0; k < N_IN; k++) begin
          if (idx_q == IDX_W'(k)) in_bits_d[k] = |readdata;
        end
      end else if (idx_q == IDX_LAST) begin
        for (int k = 0; k < N_NODE; k++) begin
          if (node_q == NODE_W'(k)) res_d[k] = sat_val;
        end
        node_d = node_q + NODE_W'(1);
        acc_d  = '0;
      end else begin
        acc_d = acc_sum;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RD;
          relu_d     = relu_en;
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
          idx_d      = '0;
          node_d     = '0;
          wr_cnt_d   = '0;
          acc_d      = '0;
          address_d  = ADDR_W'(IN_BASE);
          read_n_d   = 1'b0;
        end
      end
      S_RD: begin
        if (rd_acc) begin
          issued_d  = issued_q + CNT_W'(1);
          address_d = address_q + ADDR_W'(1);
        end
        if (issued_d == TOTAL_C) begin
          state_d  = S_DRAIN;
          read_n_d = 1'b1;
        end else begin
          read_n_d = !(outst_d < MAX_O);
        end
      end
      S_DRAIN: begin
        if (received_q == TOTAL_C) begin
          state_d     = S_WR;
          address_d   = ADDR_W'(OUT_BASE);
          writedata_d = res_pick;
          write_n_d   = 1'b0;
          wr_cnt_d    = '0;
        end
      end
      S_WR: begin
        if (wr_acc) begin
          wr_cnt_d = wr_cnt_q + NODE_W'(1);
          if (wr_cnt_d == NODE_CNT) begin
            state_d   = S_DONE;
            write_n_d = 1'b1;
          end else begin
            address_d   = address_q + ADDR_W'(1);
            writedata_d = res_pick;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RD) || (state_d == S_DRAIN) || (state_d == S_WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      relu_q      <= 1'b0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      address_q   <= '0;
      writedata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      issued_q    <= '0;
      received_q  <= '0;
      outst_q     <= '0;
      idx_q       <= '0;
      node_q      <= '0;
      wr_cnt_q    <= '0;
      acc_q       <= '0;
      in_bits_q   <= '0;
      res_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      outst_q     <= outst_d;
      idx_q       <= idx_d;
      node_q      <= node_d;
      wr_cnt_q    <= wr_cnt_d;
      acc_q       <= acc_d;
      in_bits_q   <= in_bits_d;
      res_q       <= res_d;
    end
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign state_o    = state_q;
  assign address    = address_q;
  assign read_n     = read_n_q;
  assign write_n    = write_n_q;
  assign writedata  = writedata_q;
  assign chipselect = 1'b1;
  assign byteenable = '1;

endmodule

// File: tb/tb_sdram_layer_master.sv
// Bench for sdram_layer_master: SDRAM slave model with stalls and latency, results
// checked against a plain-arithmetic model of the layer.
module tb_sdram_layer_master;
  localparam int DW = 16, AW = 32, NI = 4, NN = 2, MO = 2, IB = 16, OB = 200;
  localparam int TOTAL = NI * (NN + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, relu_en = 1'b0;
  logic          waitrequest = 1'b0, readdatavalid = 1'b0;
  logic [DW-1:0] readdata = '0, writedata;
  logic [AW-1:0] address;
  logic          read_n, write_n, chipselect, done, busy;
  logic [2:0]    state_o;
  logic [1:0]    byteenable;

  sdram_layer_master #(
    .DATA_W(DW), .ACC_W(32), .N_IN(NI), .N_NODE(NN), .ADDR_W(AW),
    .IN_BASE(IB), .OUT_BASE(OB), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .done(done), .busy(busy), .state_o(state_o), .address(address),
    .read_n(read_n), .write_n(write_n), .chipselect(chipselect),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  longint cyc = 0;
  logic [15:0] mem [0:255];

  typedef struct {logic [15:0] data; longint due;} rret_t;
  typedef struct {int a; logic [15:0] d;} wr_t;
  rret_t rq[$];
  wr_t   wlog[$];
  int    rlog[$];
  int    rd_acc_n = 0, ret_n = 0, peak = 0, viol = 0;
  int    lat = 1, wprob = 0, stall_at = -1, stall_left = 0, stall_seen = 0, spur = 0;
  longint last_wr_cyc = 0;
  logic  prev_rd_stall = 0, prev_wr_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_wd = '0;

  always @(posedge clk) cyc++;

  // Slave drives its side on the falling edge so the master samples stable inputs.
  always @(negedge clk) begin
    rret_t r;
    if (reset) begin
      rq.delete();
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      prev_rd_stall = 1'b0;
      prev_wr_stall = 1'b0;
    end else begin
      if (prev_rd_stall && (read_n !== 1'b0 || address !== prev_addr)) viol++;
      if (prev_wr_stall && (write_n !== 1'b0 || address !== prev_addr || writedata !== prev_wd)) viol++;
      if ((rd_acc_n - ret_n) >= MO && read_n === 1'b0) viol++;
      if ((rd_acc_n - ret_n) > peak) peak = rd_acc_n - ret_n;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        readdatavalid = 1'b1;
        readdata      = r.data;
        ret_n++;
      end else if (spur > 0) begin
        readdatavalid = 1'b1;
        readdata      = 16'($urandom_range(1, 65535));
        spur--;
      end else begin
        readdatavalid = 1'b0;
        readdata      = 16'($urandom);
      end
      if (stall_left > 0 && rd_acc_n == stall_at && read_n === 1'b0) begin
        waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        waitrequest = ($urandom_range(0, 99) < wprob);
      end
      prev_rd_stall = (read_n === 1'b0) && waitrequest;
      prev_wr_stall = (write_n === 1'b0) && waitrequest;
      prev_addr     = address;
      prev_wd       = writedata;
      if (read_n === 1'b0 && !waitrequest) begin
        r.data = mem[address[7:0]];
        r.due  = cyc + lat;
        rq.push_back(r);
        rd_acc_n++;
        rlog.push_back(int'(address));
      end
      if (write_n === 1'b0 && !waitrequest) begin
        wlog.push_back('{int'(address), writedata});
        last_wr_cyc = cyc + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] model(input int n, input bit relu);
    longint acc = 0;
    for (int i = 0; i < NI; i++)
      if (mem[IB + i] != 16'd0) acc += $signed(mem[IB + NI + n * NI + i]);
    if (relu && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic load(input logic [15:0] v [TOTAL]);
    for (int j = 0; j < TOTAL; j++) mem[IB + j] = v[j];
  endtask

  task automatic load_random();
    for (int i = 0; i < NI; i++)
      mem[IB + i] = $urandom_range(0, 1) ? 16'($urandom_range(1, 65535)) : 16'd0;
    for (int j = NI; j < TOTAL; j++) mem[IB + j] = 16'($urandom);
  endtask

  task automatic run_pass(input bit relu, input string tag);
    int guard, rerr;
    rd_acc_n = 0; ret_n = 0; peak = 0; viol = 0; stall_seen = 0;
    rlog.delete(); wlog.delete();
    start = 1'b1; relu_en = relu;
    tick();
    chk({tag, " busy_at_start"}, busy, 1);
    chk({tag, " state_rd"}, state_o, 1);
    relu_en = ~relu;
    guard = 0;
    while (done !== 1'b1 && guard < 3000) begin tick(); guard++; end
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " done_latency"}, cyc, last_wr_cyc);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " state_done"}, state_o, 4);
    chk({tag, " write_count"}, wlog.size(), NN);
    for (int k = 0; k < wlog.size() && k < NN; k++) begin
      chk($sformatf("%s wr%0d_addr", tag, k), wlog[k].a, OB + k);
      chk($sformatf("%s wr%0d_data", tag, k), wlog[k].d, model(k, relu));
    end
    rerr = 0;
    foreach (rlog[j]) if (rlog[j] != IB + j) rerr++;
    chk({tag, " read_count"}, rlog.size(), TOTAL);
    chk({tag, " read_addr_seq"}, rerr, 0);
    chk({tag, " returns_used"}, ret_n, TOTAL);
    chk({tag, " hold_and_window"}, viol, 0);
    chk({tag, " peak_le_max"}, (peak <= MO), 1);
    tick();
    chk({tag, " done_held"}, done, 1);
    start = 1'b0;
    tick();
    chk({tag, " back_idle"}, state_o, 0);
    chk({tag, " done_low"}, done, 0);
  endtask

  logic [15:0] vec [TOTAL];

  initial begin
    int guard;
    repeat (3) tick();
    chk("rst read_n", read_n, 1);
    chk("rst write_n", write_n, 1);
    chk("rst address", address, 0);
    chk("rst writedata", writedata, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst state", state_o, 0);
    chk("chipselect", chipselect, 1);
    chk("byteenable", byteenable, 2'b11);
    reset = 1'b0;
    spur = 3;
    repeat (5) tick();

    vec = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4,
            16'hFFFB, 16'd6, 16'hFFF9, 16'd8};
    load(vec);
    run_pass(1'b0, "vec_plain");
    chk("vec_plain res0_const", (wlog.size() > 0) ? wlog[0].d : 16'hxxxx, 16'd8);

    vec[11] = 16'hFFF8;
    load(vec);
    run_pass(1'b1, "vec_relu");

    for (int j = 0; j < TOTAL; j++) vec[j] = (j < NI) ? 16'd1 : 16'h7FFF;
    load(vec);
    run_pass(1'b0, "sat_pos");
    for (int j = NI; j < TOTAL; j++) vec[j] = 16'h8000;
    load(vec);
    run_pass(1'b0, "sat_neg");

    load_random();
    stall_at = 3; stall_left = 5;
    run_pass(1'b0, "stall");
    chk("stall cycles", stall_seen, 5);
    stall_at = -1;

    lat = 10;
    load_random();
    run_pass(1'b1, "late");
    chk("late peak", peak, MO);

    lat = 8;
    load_random();
    rd_acc_n = 0; ret_n = 0;
    start = 1'b1;
    guard = 0;
    while (!((rd_acc_n - ret_n) == 2 && state_o == 3'd1) && guard < 200) begin tick(); guard++; end
    chk("abort two_in_flight", rd_acc_n - ret_n, 2);
    reset = 1'b1;
    tick();
    chk("abort read_n", read_n, 1);
    chk("abort write_n", write_n, 1);
    chk("abort address", address, 0);
    chk("abort state", state_o, 0);
    chk("abort busy", busy, 0);
    reset = 1'b0; start = 1'b0;
    repeat (2) tick();
    load_random();
    run_pass(1'b0, "after_abort");

    for (int p = 0; p < 8; p++) begin
      lat   = $urandom_range(1, 6);
      wprob = $urandom_range(0, 50);
      load_random();
      spur  = $urandom_range(0, 2);
      repeat (3) tick();
      run_pass(1'($urandom_range(0, 1)), $sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
